// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if
// Bundles the upstream and downstream handshake signals of one pipeline
// stage register.
//   flush     : hazard-unit kill of everything held in the stage
//   in_valid  : upstream beat present
//   in_ready  : stage accepts a beat this cycle
//   in_ctrl   : upstream control bundle
//   in_data   : upstream data bundle
//   out_valid : output beat present
//   out_ready : downstream accepts the output beat this cycle
//   out_ctrl  : control bundle, zero whenever out_valid is low
//   out_data  : data bundle, holds its last value when out_valid is low
//   occ       : number of entries held in the stage
// Modport slave is the stage's view; modport master is the view of the
// logic around it (upstream, downstream and hazard control).
interface pipe_stage_skid_if #(
  parameter int CTRL_W = 12,
  parameter int DATA_W = 176
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occ;

  modport slave (
    input  flush, in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, occ
  );

  modport master (
    output flush, in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, occ
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid
// Reusable pipeline stage register placed between two core stages. Carries
// a control bundle (zeroed in bubbles) and a data bundle (only cleared by
// reset) across a valid/ready handshake, with a synchronous flush that
// turns the stage into a bubble.
//   SKID = 0 : one register, in_ready depends combinationally on out_ready.
//   SKID = 1 : main + skid register, in_ready depends on state only, so
//              no out_ready -> in_ready timing path exists.
// Ports:
//   clk  : clock, all updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : stage handshake bundle (see pipe_stage_skid_if), slave view
module pipe_stage_skid #(
  parameter int CTRL_W = 12,
  parameter int DATA_W = 176,
  parameter int SKID   = 0
) (
  input logic                 clk,
  input logic                 rst,
  pipe_stage_skid_if.slave    bus
);

  // The encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              accept;
  logic              rel;
  logic              load_main;
  logic              load_skid;
  logic              move_skid;
  logic              valid_int;

  assign valid_int = (state != EMPTY);
  assign accept    = bus.in_valid && bus.in_ready;
  assign rel       = valid_int && bus.out_ready;

  // With a skid register, ready only looks at the state flops so the
  // downstream stall never reaches upstream in the same cycle.
  always_comb begin
    if (SKID != 0) begin
      bus.in_ready = !rst && (state != TWO);
    end else begin
      bus.in_ready = !rst && (!valid_int || bus.out_ready);
    end
  end

  // Next-state and register load controls. Flush overrides every handshake
  // move, which also discards a beat accepted in the flush cycle.
  always_comb begin
    state_next = state;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    move_skid  = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_next = ONE;
          load_main  = 1'b1;
        end
      end
      ONE: begin
        if (accept && rel) begin
          state_next = ONE;
          load_main  = 1'b1;
        end else if (accept && (SKID != 0)) begin
          // Downstream stalled: park the new beat behind the held one.
          state_next = TWO;
          load_skid  = 1'b1;
        end else if (rel) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (rel) begin
          state_next = ONE;
          move_skid  = 1'b1;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
    if (bus.flush) begin
      state_next = EMPTY;
      load_main  = 1'b0;
      load_skid  = 1'b0;
      move_skid  = 1'b0;
    end
  end

  // State and bundle registers. Data registers keep their contents across
  // a flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      state <= state_next;
      if (load_main) begin
        main_ctrl <= bus.in_ctrl;
        main_data <= bus.in_data;
      end else if (move_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= bus.in_ctrl;
        skid_data <= bus.in_data;
      end
    end
  end

  assign bus.out_valid = valid_int;
  assign bus.out_ctrl  = valid_int ? main_ctrl : '0;
  assign bus.out_data  = main_data;
  assign bus.occ       = state;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid
// Drives one shared stimulus stream into two stage instances (SKID=0 and
// SKID=1). Each instance has its own reference model: a bounded FIFO of
// accepted beats (capacity 1 or 2). Stimulus pushes accepted beats into the
// model; a negedge monitor compares every DUT output against it.
module tb_pipe_stage_skid;
  localparam int CTRL_W = 12;
  localparam int DATA_W = 176;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              inValid;
  logic [CTRL_W-1:0] inCtrl;
  logic [DATA_W-1:0] inData;
  logic              outReady;

  int testsRun;
  int testsFailed;
  int beatSeq;

  beat_t             modelQ [2][3];
  int                modelCnt [2];
  logic [DATA_W-1:0] shownData [2];

  pipe_stage_skid_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) if0 ();
  pipe_stage_skid_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) if1 ();

  assign if0.flush     = flush;
  assign if0.in_valid  = inValid;
  assign if0.in_ctrl   = inCtrl;
  assign if0.in_data   = inData;
  assign if0.out_ready = outReady;
  assign if1.flush     = flush;
  assign if1.in_valid  = inValid;
  assign if1.in_ctrl   = inCtrl;
  assign if1.in_data   = inData;
  assign if1.out_ready = outReady;

  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0)
  );

  pipe_stage_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string name, input int idx,
                         input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s dut%0d at %0t: got %h expected %h",
               name, idx, $time, act, exp);
    end
  endtask

  // Compare one instance against its model, then advance the model with
  // the handshake the DUT is about to see on the next rising edge.
  task automatic checkOutput(input int idx, input logic actInReady,
                             input logic actOutValid,
                             input logic [CTRL_W-1:0] actOutCtrl,
                             input logic [DATA_W-1:0] actOutData,
                             input logic [1:0] actOcc);
    int   cap;
    logic expValid;
    logic expReady;
    logic [CTRL_W-1:0] expCtrl;
    logic [DATA_W-1:0] expData;
    cap      = (idx == 0) ? 1 : 2;
    expValid = (modelCnt[idx] > 0);
    expCtrl  = expValid ? modelQ[idx][0].ctrl : '0;
    expData  = expValid ? modelQ[idx][0].data : shownData[idx];
    if (idx == 0) expReady = !rst && (modelCnt[idx] == 0 || outReady);
    else          expReady = !rst && (modelCnt[idx] < cap);

    compare("in_ready",  idx, DATA_W'(actInReady),  DATA_W'(expReady));
    compare("out_valid", idx, DATA_W'(actOutValid), DATA_W'(expValid));
    compare("out_ctrl",  idx, DATA_W'(actOutCtrl),  DATA_W'(expCtrl));
    compare("out_data",  idx, actOutData,           expData);
    compare("occ",       idx, DATA_W'(actOcc),      DATA_W'(modelCnt[idx]));

    if (rst) begin
      modelCnt[idx]  = 0;
      shownData[idx] = '0;
    end else if (flush) begin
      modelCnt[idx] = 0;
    end else begin
      if (actOutValid && outReady && modelCnt[idx] > 0) begin
        for (int k = 0; k < 2; k++) modelQ[idx][k] = modelQ[idx][k+1];
        modelCnt[idx]--;
      end
      if (actInReady && inValid && modelCnt[idx] < 3) begin
        modelQ[idx][modelCnt[idx]] = {inCtrl, inData};
        modelCnt[idx]++;
      end
      if (modelCnt[idx] > 0) shownData[idx] = modelQ[idx][0].data;
    end
  endtask

  always @(negedge clk) begin
    checkOutput(0, if0.in_ready, if0.out_valid, if0.out_ctrl, if0.out_data, if0.occ);
    checkOutput(1, if1.in_ready, if1.out_valid, if1.out_ctrl, if1.out_data, if1.occ);
  end

  function automatic logic [DATA_W-1:0] mkData(input int n);
    logic [15:0] low;
    low = n[15:0];
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), low};
  endfunction

  task automatic applyStimulus(input logic r, input logic f, input logic v,
                               input logic [CTRL_W-1:0] c,
                               input logic [DATA_W-1:0] d,
                               input logic ordy);
    rst      = r;
    flush    = f;
    inValid  = v;
    inCtrl   = c;
    inData   = d;
    outReady = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic sendBeat(input logic v, input logic [CTRL_W-1:0] c,
                          input logic ordy, input logic f);
    beatSeq++;
    applyStimulus(1'b0, f, v, c, mkData(beatSeq), ordy);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    beatSeq     = 0;
    for (int i = 0; i < 2; i++) begin
      modelCnt[i]  = 0;
      shownData[i] = '0;
    end
    rst      = 1'b1;
    flush    = 1'b0;
    inValid  = 1'b1;
    inCtrl   = 12'hFFF;
    inData   = '1;
    outReady = 1'b1;

    // Reset held two cycles with a beat offered.
    applyStimulus(1'b1, 1'b0, 1'b1, 12'hFFF, '1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 12'hFFF, '1, 1'b1);

    // Streaming with data 1..8.
    for (int i = 1; i <= 8; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, CTRL_W'(i), DATA_W'(i), 1'b1);
    sendBeat(1'b0, 12'h000, 1'b1, 1'b0);

    // Stall: A then B with downstream blocked, then drain.
    sendBeat(1'b1, 12'h0A0, 1'b0, 1'b0);
    sendBeat(1'b1, 12'h0B0, 1'b0, 1'b0);
    sendBeat(1'b0, 12'h000, 1'b0, 1'b0);
    sendBeat(1'b0, 12'h000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) sendBeat(1'b0, 12'h000, 1'b1, 1'b0);

    // Flush while full, with beat C offered in the flush cycle.
    sendBeat(1'b1, 12'h0D0, 1'b0, 1'b0);
    sendBeat(1'b1, 12'h0E0, 1'b0, 1'b0);
    sendBeat(1'b1, 12'h0C0, 1'b0, 1'b1);
    sendBeat(1'b0, 12'h000, 1'b1, 1'b0);
    sendBeat(1'b0, 12'h000, 1'b1, 1'b0);

    // Bubble in the middle of a stream.
    sendBeat(1'b1, 12'h123, 1'b1, 1'b0);
    sendBeat(1'b1, 12'hABC, 1'b1, 1'b0);
    sendBeat(1'b0, 12'h000, 1'b1, 1'b0);
    sendBeat(1'b1, 12'h456, 1'b1, 1'b0);
    sendBeat(1'b0, 12'h000, 1'b1, 1'b0);

    // Flush and reset together.
    sendBeat(1'b1, 12'h777, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 12'h888, '1, 1'b0);
    sendBeat(1'b0, 12'h000, 1'b1, 1'b0);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      logic r;
      logic f;
      logic v;
      logic o;
      r = ($urandom_range(0, 199) == 0);
      f = ($urandom_range(0, 24) == 0);
      v = ($urandom_range(0, 9) < 7);
      o = ($urandom_range(0, 9) < 6);
      beatSeq++;
      applyStimulus(r, f, v, CTRL_W'($urandom()), mkData(beatSeq), o);
    end

    for (int i = 0; i < 4; i++) sendBeat(1'b0, 12'h000, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
